// File: rtl/tm_pkg.sv
// Shared types and sizing helpers for the time-multiplexed Tsetlin Machine inference engine.
package tm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } tm_state_t;

    // Wide enough to hold +/- n_clauses/2, so the raw vote never overflows.
    function automatic int tm_sum_w(input int n_clauses);
        return $clog2(n_clauses / 2 + 1) + 1;
    endfunction

    function automatic int tm_idx_w(input int n_clauses);
        return (n_clauses > 1) ? $clog2(n_clauses) : 1;
    endfunction

    function automatic int tm_lit_pos(input int i);
        return i;
    endfunction

    function automatic int tm_lit_neg(input int n_features, input int i);
        return n_features + i;
    endfunction

endpackage

// File: rtl/tm_clause_eval.sv
// One Tsetlin clause: AND over all included literals of the feature vector.
module tm_clause_eval
    import tm_pkg::*;
#(
    parameter int N_FEATURES       = 784,
    parameter bit EMPTY_CLAUSE_OUT = 1'b0
) (
    input  logic [N_FEATURES-1:0]   i_features,
    input  logic [2*N_FEATURES-1:0] i_exclude,
    output logic                    o_clause
);

    logic [N_FEATURES-1:0] w_pos_ok;
    logic [N_FEATURES-1:0] w_neg_ok;

    always_comb begin
        for (int i = 0; i < N_FEATURES; i++) begin
            w_pos_ok[i] = i_features[i]  | i_exclude[tm_lit_pos(i)];
            w_neg_ok[i] = ~i_features[i] | i_exclude[tm_lit_neg(N_FEATURES, i)];
        end
    end

    assign o_clause = (&i_exclude) ? EMPTY_CLAUSE_OUT : ((&w_pos_ok) & (&w_neg_ok));

endmodule

// File: rtl/tm_inference_seq.sv
// Time-multiplexed single-class Tsetlin Machine inference: LANES clauses per cycle,
// clamped polarity vote returned through a valid/ready handshake.
module tm_inference_seq
    import tm_pkg::*;
#(
    parameter int N_FEATURES       = 784,
    parameter int N_CLAUSES        = 20,
    parameter int LANES            = 4,
    parameter int THRESH           = 15,
    parameter bit EMPTY_CLAUSE_OUT = 1'b0,
    localparam int SUM_W           = tm_sum_w(N_CLAUSES),
    localparam int IDX_W           = tm_idx_w(N_CLAUSES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [IDX_W-1:0]        cfg_addr,
    input  logic [2*N_FEATURES-1:0] cfg_exclude,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_FEATURES-1:0]   in_features,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_verdict,
    output logic signed [SUM_W-1:0] out_sum,
    output logic [N_CLAUSES-1:0]    out_clause,
    output logic                    busy
);

    localparam int STEPS   = N_CLAUSES / LANES;
    localparam int HALF    = N_CLAUSES / 2;
    localparam int TH_EFF  = (THRESH < HALF) ? THRESH : HALF;
    localparam int ADDR_W1 = IDX_W + 1;

    localparam logic signed [SUM_W-1:0] TH_POS    = SUM_W'(TH_EFF);
    localparam logic signed [SUM_W-1:0] TH_NEG    = -TH_POS;
    localparam logic signed [SUM_W-1:0] ONE_S     = SUM_W'(1);
    localparam logic [ADDR_W1-1:0]      ADDR_LIM  = ADDR_W1'(N_CLAUSES);
    localparam logic [IDX_W-1:0]        LANES_I   = IDX_W'(LANES);
    localparam logic [IDX_W-1:0]        HALF_I    = IDX_W'(HALF);
    localparam logic [IDX_W-1:0]        LAST_STEP = IDX_W'(STEPS - 1);
    localparam logic [IDX_W-1:0]        ONE_I     = IDX_W'(1);

    tm_state_t r_state;
    tm_state_t w_state_nxt;

    logic [2*N_FEATURES-1:0] r_mask [N_CLAUSES];
    logic [N_FEATURES-1:0]   r_features;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        r_steps_left;
    logic signed [SUM_W-1:0] r_acc;
    logic signed [SUM_W-1:0] r_sum;
    logic                    r_verdict;
    logic [N_CLAUSES-1:0]    r_clause;

    logic [IDX_W-1:0]        w_cidx [LANES];
    logic [LANES-1:0]        w_lane_out;
    logic signed [SUM_W-1:0] w_lane_total;
    logic signed [SUM_W-1:0] w_acc_nxt;
    logic signed [SUM_W-1:0] w_sum_clamped;
    logic                    w_accept;
    logic                    w_cfg_wr;
    logic                    w_last_step;

    assign w_accept    = (r_state == IDLE) && in_valid;
    assign w_cfg_wr    = (r_state == IDLE) && cfg_we && ({1'b0, cfg_addr} < ADDR_LIM);
    assign w_last_step = (r_state == EVAL) && (r_steps_left == '0);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_cidx[l] = r_idx + IDX_W'(l);

        tm_clause_eval #(
            .N_FEATURES       (N_FEATURES),
            .EMPTY_CLAUSE_OUT (EMPTY_CLAUSE_OUT)
        ) u_clause (
            .i_features (r_features),
            .i_exclude  (r_mask[w_cidx[l]]),
            .o_clause   (w_lane_out[l])
        );
    end

    // A lane group may straddle the +/- boundary, so polarity is decided per lane.
    always_comb begin
        w_lane_total = '0;
        for (int l = 0; l < LANES; l++) begin
            if (w_lane_out[l]) begin
                if (w_cidx[l] < HALF_I) w_lane_total = w_lane_total + ONE_S;
                else                    w_lane_total = w_lane_total - ONE_S;
            end
        end
    end

    assign w_acc_nxt = r_acc + w_lane_total;

    always_comb begin
        w_sum_clamped = w_acc_nxt;
        if (w_acc_nxt > TH_POS)      w_sum_clamped = TH_POS;
        else if (w_acc_nxt < TH_NEG) w_sum_clamped = TH_NEG;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)    w_state_nxt = EVAL;
            EVAL:    if (w_last_step) w_state_nxt = DONE;
            DONE:    if (out_ready)   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CLAUSES; c++) r_mask[c] <= '1;
        end else if (w_cfg_wr) begin
            r_mask[cfg_addr] <= cfg_exclude;
        end
    end

    // Index stops at the last group so lane addresses never leave the mask array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_features   <= '0;
            r_idx        <= '0;
            r_steps_left <= '0;
            r_acc        <= '0;
            r_sum        <= '0;
            r_verdict    <= 1'b0;
            r_clause     <= '0;
        end else if (w_accept) begin
            r_features   <= in_features;
            r_idx        <= '0;
            r_steps_left <= LAST_STEP;
            r_acc        <= '0;
            r_clause     <= '0;
        end else if (r_state == EVAL) begin
            r_acc <= w_acc_nxt;
            for (int l = 0; l < LANES; l++) r_clause[w_cidx[l]] <= w_lane_out[l];
            if (w_last_step) begin
                r_sum     <= w_sum_clamped;
                r_verdict <= !w_sum_clamped[SUM_W-1] && (w_sum_clamped != '0);
            end else begin
                r_idx        <= r_idx + LANES_I;
                r_steps_left <= r_steps_left - ONE_I;
            end
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign out_sum     = r_sum;
    assign out_verdict = r_verdict;
    assign out_clause  = r_clause;

endmodule
